comp_reporter: RTL and testbench

Completion reporter that drains the completion-address queue and serialises each AES/SHA destination address into a framed byte stream toward the host-facing transmit path. It is the consumer end of the queue's valid/ready output: it accepts one address, emits a header byte, the address bytes MSB-first and an XOR checksum byte, then returns for the next address. It also provides a one-cycle frame-done strobe and a running frame counter for status/interrupt logic.

---
 rtl/comp_reporter.sv | 95 +++++++++
 tb/tb_comp_reporter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/comp_reporter.sv
// Completion reporter: drains completion addresses and frames each one as
// header, address bytes MSB-first, then an XOR checksum over the address bytes.
module comp_reporter #(
   parameter int         ADDRW = 24,
   parameter logic [7:0] HDR   = 8'hC5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [ADDRW-1:0] comp_addr,
   input  logic             comp_valid,
   output logic             comp_ready,
   output logic [7:0]       tx_data,
   output logic             tx_valid,
   input  logic             tx_ready,
   output logic             frame_done,
   output logic [15:0]      frame_count
);

   localparam int NBYTES = ADDRW / 8;
   localparam int IW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;

   typedef enum logic [1:0] {ST_IDLE, ST_HDR, ST_ADDR, ST_CSUM} state_t;

   state_t           state, state_nxt;
   logic [ADDRW-1:0] shift;
   logic [7:0]       csum;
   logic [IW-1:0]    idx;
   logic             accept;
   logic             beat;

   function automatic logic [7:0] xor_bytes(input logic [ADDRW-1:0] a);
      logic [7:0] r;
      r = 8'h00;
      for (int i = 0; i < NBYTES; i++) r = r ^ a[i*8 +: 8];
      return r;
   endfunction

   always_comb begin
      state_nxt  = state;
      comp_ready = 1'b0;
      tx_valid   = 1'b0;
      tx_data    = 8'h00;
      case (state)
         ST_IDLE: begin
            // Held low during reset so the queue never hands over an address
            // that would be lost when the frame state is cleared.
            comp_ready = !rst;
            if (comp_valid && !rst) state_nxt = ST_HDR;
         end
         ST_HDR: begin
            tx_valid = 1'b1;
            tx_data  = HDR;
            if (tx_ready) state_nxt = ST_ADDR;
         end
         ST_ADDR: begin
            tx_valid = 1'b1;
            tx_data  = shift[ADDRW-1 -: 8];
            if (tx_ready && idx == IW'(NBYTES - 1)) state_nxt = ST_CSUM;
         end
         ST_CSUM: begin
            tx_valid = 1'b1;
            tx_data  = csum;
            if (tx_ready) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign accept = comp_valid && comp_ready;
   assign beat   = tx_valid && tx_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ST_IDLE;
         shift       <= '0;
         csum        <= 8'h00;
         idx         <= '0;
         frame_done  <= 1'b0;
         frame_count <= 16'h0000;
      end else begin
         state      <= state_nxt;
         frame_done <= (state == ST_CSUM) && beat;
         if (accept) begin
            shift <= comp_addr;
            csum  <= xor_bytes(comp_addr);
            idx   <= '0;
         end else if (state == ST_ADDR && beat) begin
            shift <= shift << 8;
            idx   <= idx + IW'(1);
         end
         if (state == ST_CSUM && beat) frame_count <= frame_count + 16'd1;
      end
   end

endmodule

// File: tb/tb_comp_reporter.sv
// Bench for comp_reporter: byte-queue reference model checked every cycle,
// plus literal frame expectations for each directed scenario.
module tb_comp_reporter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [23:0] comp_addr = '0;
   logic        comp_valid = 1'b0;
   logic        comp_ready;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready = 1'b1;
   logic        frame_done;
   logic [15:0] frame_count;

   logic [31:0] addr32 = '0;
   logic        valid32 = 1'b0;
   logic        ready32;
   logic [7:0]  data32;
   logic        txv32;
   logic        txr32 = 1'b1;
   logic        done32;
   logic [15:0] count32;

   comp_reporter dut (
      .clk(clk), .rst(rst), .comp_addr(comp_addr), .comp_valid(comp_valid),
      .comp_ready(comp_ready), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_ready(tx_ready), .frame_done(frame_done), .frame_count(frame_count)
   );

   comp_reporter #(.ADDRW(32), .HDR(8'h5A)) dut32 (
      .clk(clk), .rst(rst), .comp_addr(addr32), .comp_valid(valid32),
      .comp_ready(ready32), .tx_data(data32), .tx_valid(txv32),
      .tx_ready(txr32), .frame_done(done32), .frame_count(count32)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: pending frame bytes, completed-frame count, done pulse.
   logic [7:0]  q[$];
   logic [15:0] m_count = 16'h0000;
   logic        m_done = 1'b0;
   int          cyc = 0;
   int          acc_times[$];
   logic [7:0]  seen[$];
   logic [7:0]  exp_b[10];

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         q.delete();
         m_count = 16'h0000;
         m_done  = 1'b0;
      end else begin
         logic [7:0] cs;
         m_done = 1'b0;
         if (q.size() == 0) begin
            if (comp_valid) begin
               cs = 8'h00;
               q.push_back(8'hC5);
               for (int i = 2; i >= 0; i--) begin
                  q.push_back(comp_addr[i*8 +: 8]);
                  cs = cs ^ comp_addr[i*8 +: 8];
               end
               q.push_back(cs);
            end
         end else if (tx_ready) begin
            void'(q.pop_front());
            if (q.size() == 0) begin
               m_done  = 1'b1;
               m_count = m_count + 16'd1;
            end
         end
      end
   end

   always @(posedge clk) begin
      cyc++;
      if (comp_valid && comp_ready && !rst) acc_times.push_back(cyc);
   end

   always @(negedge clk) begin
      if (!rst) begin
         chk("comp_ready", {31'b0, comp_ready}, {31'b0, q.size() == 0});
         chk("tx_valid", {31'b0, tx_valid}, {31'b0, q.size() != 0});
         if (q.size() != 0) chk("tx_data", {24'b0, tx_data}, {24'b0, q[0]});
         chk("frame_done", {31'b0, frame_done}, {31'b0, m_done});
         chk("frame_count", {16'b0, frame_count}, {16'b0, m_count});
         if (tx_valid && tx_ready) seen.push_back(tx_data);
      end
   end

   task automatic send(input logic [23:0] a);
      @(posedge clk); #1;
      comp_valid = 1'b1;
      comp_addr  = a;
      @(posedge clk); #1;
      comp_valid = 1'b0;
   endtask

   task automatic wait_done(input string nm);
      bit got = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (frame_done) begin
            got = 1'b1;
            break;
         end
      end
      chk({nm, "_done_seen"}, {31'b0, got}, 32'd1);
   endtask

   task automatic check_bytes(input string nm, input int n);
      chk({nm, "_nbytes"}, seen.size(), n);
      for (int i = 0; i < n && i < seen.size(); i++)
         chk($sformatf("%s_byte%0d", nm, i), {24'b0, seen[i]}, {24'b0, exp_b[i]});
   endtask

   localparam logic [7:0] PAT [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
   localparam logic [7:0] EXP32 [6] = '{8'h5A, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22};

   initial begin
      #2;
      chk("rst_comp_ready", {31'b0, comp_ready}, 32'd0);
      chk("rst_tx_valid", {31'b0, tx_valid}, 32'd0);
      chk("rst_tx_data", {24'b0, tx_data}, 32'd0);
      chk("rst_frame_done", {31'b0, frame_done}, 32'd0);
      chk("rst_frame_count", {16'b0, frame_count}, 32'd0);
      @(posedge clk); @(posedge clk); #2;
      rst = 1'b0;

      // Single frame, tx_ready held high.
      seen.delete();
      send(24'h123456);
      wait_done("single");
      chk("single_count", {16'b0, frame_count}, 32'd1);
      exp_b = '{8'hC5, 8'h12, 8'h34, 8'h56, 8'h70, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      check_bytes("single", 5);
      @(negedge clk);
      chk("single_done_pulse_width", {31'b0, frame_done}, 32'd0);

      // Same frame with downstream stalls.
      seen.delete();
      fork
         send(24'h123456);
         for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            tx_ready = PAT[i % 4][0];
         end
         wait_done("stall");
      join
      tx_ready = 1'b1;
      check_bytes("stall", 5);
      chk("stall_count", {16'b0, frame_count}, 32'd2);

      // Back-to-back addresses with comp_valid held.
      seen.delete();
      acc_times.delete();
      @(posedge clk); #1;
      comp_valid = 1'b1;
      comp_addr  = 24'hABCDEF;
      @(posedge clk); #1;
      comp_addr  = 24'h000001;
      for (int i = 0; i < 50; i++) begin
         if (acc_times.size() >= 2) break;
         @(posedge clk); #1;
      end
      comp_valid = 1'b0;
      chk("b2b_accepts", acc_times.size(), 2);
      if (acc_times.size() >= 2) chk("b2b_spacing", acc_times[1] - acc_times[0], 6);
      wait_done("b2b");
      exp_b = '{8'hC5, 8'hAB, 8'hCD, 8'hEF, 8'h89, 8'hC5, 8'h00, 8'h00, 8'h01, 8'h01};
      check_bytes("b2b", 10);
      chk("b2b_count", {16'b0, frame_count}, 32'd4);

      // Asynchronous reset in the middle of the address bytes.
      send(24'h777777);
      @(posedge clk); #3;
      rst = 1'b1;
      #1;
      chk("arst_tx_valid", {31'b0, tx_valid}, 32'd0);
      chk("arst_comp_ready", {31'b0, comp_ready}, 32'd0);
      chk("arst_frame_count", {16'b0, frame_count}, 32'd0);
      @(posedge clk); #2;
      rst = 1'b0;
      seen.delete();
      send(24'h00FF00);
      wait_done("post_rst");
      exp_b = '{8'hC5, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      check_bytes("post_rst", 5);
      chk("post_rst_count", {16'b0, frame_count}, 32'd1);

      // Counter wrap: preload the count to its maximum, then one more frame.
      @(posedge clk); #1;
      force dut.frame_count = 16'hFFFF;
      m_count = 16'hFFFF;
      #1;
      release dut.frame_count;
      send(24'h0A0B0C);
      wait_done("wrap");
      chk("wrap_count", {16'b0, frame_count}, 32'd0);

      // 32-bit address, alternate header.
      @(posedge clk); #1;
      valid32 = 1'b1;
      addr32  = 32'hDEADBEEF;
      @(posedge clk); #1;
      valid32 = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         chk($sformatf("w32_valid%0d", k), {31'b0, txv32}, 32'd1);
         chk($sformatf("w32_byte%0d", k), {24'b0, data32}, {24'b0, EXP32[k]});
      end
      @(negedge clk);
      chk("w32_done", {31'b0, done32}, 32'd1);
      chk("w32_count", {16'b0, count32}, 32'd1);
      chk("w32_ready", {31'b0, ready32}, 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete, errors=%0d", errors);
      $fatal(1);
   end

endmodule
